// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-aware write arbiter sharing one FIFO write port among
// NUM_REQ producers; a grant is held until last beat, MAX_BURST beats or abandonment.
`timescale 1ns/1ps

module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 16
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        i_en,
    input  logic [NUM_REQ-1:0]          i_req,
    input  logic [NUM_REQ*DATA_W-1:0]   i_data,
    input  logic [NUM_REQ-1:0]          i_last,
    output logic [NUM_REQ-1:0]          o_ack,
    output logic [NUM_REQ-1:0]          o_grant,
    output logic [$clog2(NUM_REQ)-1:0]  o_grant_id,
    output logic                        o_busy,
    input  logic                        i_fifo_full,
    output logic                        o_fifo_wren,
    output logic [DATA_W-1:0]           o_fifo_wrdata
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST) + 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

    logic [0:0]         state;
    logic [IW-1:0]      g;
    logic [IW-1:0]      rr_ptr;
    logic [BW-1:0]      bcnt;

    logic               pick_valid;
    logic [IW-1:0]      pick_idx;
    logic               locked;
    logic               xfer;
    logic               burst_end;
    logic               release_now;
    logic [NUM_REQ-1:0] g_onehot;

    // Modular add that also works when NUM_REQ is not a power of two.
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_REQ)
            sum = sum - NUM_REQ;
        return IW'(sum);
    endfunction

    // Scan from the highest offset down so the requester nearest rr_ptr wins.
    always_comb begin
        // NOTE: defaults before the loop keep this purely combinational (no latch).
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (i_req[wrap_add(rr_ptr, i)]) begin
                pick_valid = 1'b1;
                pick_idx   = wrap_add(rr_ptr, i);
            end
        end
    end

    assign locked      = (state == ST_LOCK);
    assign g_onehot    = NUM_REQ'(1) << g;
    assign xfer        = rstn & i_en & locked & i_req[g] & ~i_fifo_full;
    assign burst_end   = (bcnt == BW'(MAX_BURST - 1));
    assign release_now = i_en & locked & ((xfer & (i_last[g] | burst_end)) | ~i_req[g]);

    // Write-side outputs are masked by rstn so nothing is written in a reset cycle.
    assign o_busy        = locked;
    assign o_grant       = locked ? g_onehot : '0;
    assign o_grant_id    = locked ? g : '0;
    assign o_ack         = xfer ? g_onehot : '0;
    assign o_fifo_wren   = xfer;
    assign o_fifo_wrdata = (rstn & locked) ? i_data[int'(g)*DATA_W +: DATA_W] : '0;

    always_ff @(posedge clk) begin
        // NOTE: all state uses non-blocking assignment so every register samples pre-edge values.
        if (!rstn) begin
            state  <= ST_IDLE;
            g      <= '0;
            rr_ptr <= '0;
            bcnt   <= '0;
        end else if (i_en) begin
            if (!locked) begin
                if (pick_valid) begin
                    state <= ST_LOCK;
                    g     <= pick_idx;
                    bcnt  <= '0;
                end
            end else if (release_now) begin
                state  <= ST_IDLE;
                rr_ptr <= wrap_add(g, 1);
                bcnt   <= '0;
            end else if (xfer) begin
                bcnt <= bcnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: producers feed per-requester beat queues,
// expected FIFO writes are queued up front and a monitor pops them on each write.
`timescale 1ns/1ps

module tb_fifo_wr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 16;

    typedef struct packed { logic l; logic [7:0] d; } beat_t;
    typedef struct packed { logic [1:0] id; logic [7:0] d; } exp_t;

    logic                      clk = 1'b0;
    logic                      rstn = 1'b0;
    logic                      i_en = 1'b1;
    logic [NUM_REQ-1:0]        i_req = '0;
    logic [NUM_REQ*DATA_W-1:0] i_data = '0;
    logic [NUM_REQ-1:0]        i_last = '0;
    logic [NUM_REQ-1:0]        o_ack;
    logic [NUM_REQ-1:0]        o_grant;
    logic [1:0]                o_grant_id;
    logic                      o_busy;
    logic                      i_fifo_full = 1'b0;
    logic                      o_fifo_wren;
    logic [DATA_W-1:0]         o_fifo_wrdata;

    beat_t src_q[NUM_REQ][$];
    exp_t  sb[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    fifo_wr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rstn(rstn), .i_en(i_en), .i_req(i_req), .i_data(i_data),
        .i_last(i_last), .o_ack(o_ack), .o_grant(o_grant), .o_grant_id(o_grant_id),
        .o_busy(o_busy), .i_fifo_full(i_fifo_full), .o_fifo_wren(o_fifo_wren),
        .o_fifo_wrdata(o_fifo_wrdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_beat(input int k, input logic [7:0] d, input logic l);
        beat_t b;
        b.d = d;
        b.l = l;
        src_q[k].push_back(b);
    endtask

    task automatic expect_wr(input int k, input logic [7:0] d);
        exp_t e;
        e.id = 2'(k);
        e.d  = d;
        sb.push_back(e);
    endtask

    function automatic bit all_idle();
        bit idle;
        idle = (sb.size() == 0) && !o_busy;
        for (int k = 0; k < NUM_REQ; k++)
            if (src_q[k].size() != 0) idle = 1'b0;
        return idle;
    endfunction

    task automatic drain(input string name, input int budget);
        bit done;
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            @(posedge clk);
            #1;
            done = all_idle();
        end
        check(name, done, 1);
    endtask

    // Producers: present head beat, retire it once the DUT acknowledged it.
    initial begin
        logic [NUM_REQ-1:0] ack_s;
        beat_t              popped;
        forever begin
            @(negedge clk);
            ack_s = o_ack;
            @(posedge clk);
            #1;
            for (int k = 0; k < NUM_REQ; k++)
                if (ack_s[k] && src_q[k].size() != 0) popped = src_q[k].pop_front();
            #1;
            for (int k = 0; k < NUM_REQ; k++) begin
                i_req[k]              = (src_q[k].size() != 0);
                i_data[k*DATA_W +: 8] = (src_q[k].size() != 0) ? src_q[k][0].d : 8'h00;
                i_last[k]             = (src_q[k].size() != 0) ? src_q[k][0].l : 1'b0;
            end
        end
    end

    // Monitor: every FIFO write must match the next expected beat.
    always @(negedge clk) begin
        exp_t e;
        if (o_fifo_wren) begin
            check("wr_while_full", i_fifo_full, 0);
            check("wr_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("wr_data", o_fifo_wrdata, e.d);
                check("wr_id", o_grant_id, e.id);
                check("wr_ack", o_ack, 4'b0001 << e.id);
            end
        end else begin
            check("ack_idle", o_ack, 0);
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_grant", o_grant, 0);
        check("rst_grant_id", o_grant_id, 0);
        check("rst_busy", o_busy, 0);
        check("rst_ack", o_ack, 0);
        check("rst_wren", o_fifo_wren, 0);
        check("rst_wrdata", o_fifo_wrdata, 0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        cyc(1);

        // Single requester 1, 3-beat packet
        push_beat(1, 8'hA1, 0); push_beat(1, 8'hA2, 0); push_beat(1, 8'hA3, 1);
        expect_wr(1, 8'hA1); expect_wr(1, 8'hA2); expect_wr(1, 8'hA3);
        @(negedge clk);
        check("t1_arb_busy", o_busy, 0);
        check("t1_arb_wren", o_fifo_wren, 0);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("t1_busy", o_busy, i <= 3);
            check("t1_wren", o_fifo_wren, i <= 3);
            if (i == 1) begin
                check("t1_grant", o_grant, 4'b0010);
                check("t1_grant_id", o_grant_id, 1);
            end
        end
        drain("t1_drain", 50);
        // rr_ptr is now 2: requester 2 beats requester 0
        push_beat(0, 8'h02, 1); push_beat(2, 8'h22, 1);
        expect_wr(2, 8'h22); expect_wr(0, 8'h02);
        drain("t1_rr_drain", 50);

        // All four requesters streaming 1-beat packets from reset
        rstn = 1'b0;
        cyc(2);
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < NUM_REQ; k++) begin
                push_beat(k, 8'((r + 1) * 16 + k), 1);
                expect_wr(k, 8'((r + 1) * 16 + k));
            end
        cyc(1);
        rstn = 1'b1;
        @(negedge clk);
        check("t2_arb_wren", o_fifo_wren, 0);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("t2_wren_pattern", o_fifo_wren, (i % 2) == 0);
        end
        drain("t2_drain", 50);

        // Forced release after MAX_BURST beats; waiting requester 3 goes next
        for (int i = 0; i < 20; i++) push_beat(2, 8'(8'hC0 + i), 0);
        for (int i = 0; i < 16; i++) expect_wr(2, 8'(8'hC0 + i));
        expect_wr(3, 8'h31); expect_wr(3, 8'h32);
        for (int i = 16; i < 20; i++) expect_wr(2, 8'(8'hC0 + i));
        cyc(3);
        push_beat(3, 8'h31, 0); push_beat(3, 8'h32, 1);
        drain("t3_drain", 200);

        // FIFO full for 5 cycles mid-packet, then enable low for 2 cycles
        for (int i = 0; i < 6; i++) begin
            push_beat(0, 8'(8'hE0 + i), i == 5);
            expect_wr(0, 8'(8'hE0 + i));
        end
        cyc(3);
        i_fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_full_wren", o_fifo_wren, 0);
            check("t4_full_busy", o_busy, 1);
            check("t4_full_grant", o_grant, 4'b0001);
            cyc(1);
        end
        i_fifo_full = 1'b0;
        cyc(1);
        i_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("t4_dis_wren", o_fifo_wren, 0);
            check("t4_dis_grant", o_grant, 4'b0001);
            cyc(1);
        end
        i_en = 1'b1;
        drain("t4_drain", 50);

        // Granted requester 1 abandons after one beat
        push_beat(1, 8'h5A, 0);
        expect_wr(1, 8'h5A);
        @(negedge clk);
        check("t5_arb_busy", o_busy, 0);
        @(negedge clk);
        check("t5_wren", o_fifo_wren, 1);
        check("t5_grant_id", o_grant_id, 1);
        @(negedge clk);
        check("t5_abandon_wren", o_fifo_wren, 0);
        check("t5_abandon_busy", o_busy, 1);
        @(negedge clk);
        check("t5_idle_busy", o_busy, 0);
        cyc(1);
        // rr_ptr is now 2: requester 3 beats requester 0
        push_beat(0, 8'h0B, 1); push_beat(3, 8'h3B, 1);
        expect_wr(3, 8'h3B); expect_wr(0, 8'h0B);
        drain("t5_drain", 50);

        // Reset during a packet at beat 2
        push_beat(3, 8'h71, 0); push_beat(3, 8'h72, 0);
        push_beat(3, 8'h73, 0); push_beat(3, 8'h74, 1);
        expect_wr(3, 8'h71);
        cyc(2);
        rstn = 1'b0;
        @(negedge clk);
        check("t6_rstcyc_wren", o_fifo_wren, 0);
        check("t6_rstcyc_ack", o_ack, 0);
        cyc(1);
        src_q[3].delete();
        @(negedge clk);
        check("t6_grant", o_grant, 0);
        check("t6_grant_id", o_grant_id, 0);
        check("t6_busy", o_busy, 0);
        check("t6_wren", o_fifo_wren, 0);
        check("t6_wrdata", o_fifo_wrdata, 0);
        cyc(1);
        rstn = 1'b1;
        push_beat(3, 8'h3C, 1); push_beat(0, 8'h0C, 1);
        expect_wr(0, 8'h0C); expect_wr(3, 8'h3C);
        drain("t6_drain", 50);

        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
